// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - execute-stage ALU with funct decode and iterative mul/div
module alu_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [1:0]       ALUOp_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic [3:0]       alu_ctrl_o,
    output logic             illegal_o
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;
    localparam logic [3:0] CTRL_MUL  = 4'b1000;
    localparam logic [3:0] CTRL_DIVU = 4'b1001;
    localparam logic [3:0] CTRL_REMU = 4'b1010;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      op_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q;

    logic [3:0]       dec_ctrl;
    logic             dec_illegal;
    logic             dec_multi;
    logic             accept;
    logic [WIDTH-1:0] single_res;

    logic [WIDTH:0]   rem_shift, rem_diff;
    logic             rem_ge;
    logic [WIDTH-1:0] a_next, b_next, acc_next, final_res;

    assign ready_o = (state_q == IDLE);
    assign accept  = valid_i && (state_q == IDLE) && !flush_i;

    always_comb begin
        dec_ctrl    = 4'b0000;
        dec_illegal = 1'b0;
        case (ALUOp_i)
            2'b00: dec_ctrl = CTRL_ADD;
            2'b01: dec_ctrl = CTRL_SUB;
            2'b10: begin
                case (funct_i)
                    6'b100011: dec_ctrl = CTRL_ADD;
                    6'b100001: dec_ctrl = CTRL_SUB;
                    6'b100110: dec_ctrl = CTRL_AND;
                    6'b100101: dec_ctrl = CTRL_OR;
                    6'b101011: dec_ctrl = CTRL_NOR;
                    6'b101000: dec_ctrl = CTRL_SLT;
                    6'b011000: dec_ctrl = CTRL_MUL;
                    6'b011011: dec_ctrl = CTRL_DIVU;
                    6'b011001: dec_ctrl = CTRL_REMU;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        dec_multi = !dec_illegal &&
                    ((dec_ctrl == CTRL_MUL) || (dec_ctrl == CTRL_DIVU) || (dec_ctrl == CTRL_REMU));
    end

    // Illegal requests decode to the AND code, so the result must be forced to zero here.
    always_comb begin
        single_res = '0;
        if (!dec_illegal) begin
            case (dec_ctrl)
                CTRL_ADD: single_res = src1_i + src2_i;
                CTRL_SUB: single_res = src1_i - src2_i;
                CTRL_AND: single_res = src1_i & src2_i;
                CTRL_OR:  single_res = src1_i | src2_i;
                CTRL_NOR: single_res = ~(src1_i | src2_i);
                CTRL_SLT: single_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
                default:  single_res = '0;
            endcase
        end
    end

    // a_q: multiplicand (mul) or dividend/quotient shift register (div); acc_q: product or remainder.
    always_comb begin
        rem_shift = {acc_q, a_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, b_q};
        rem_ge    = ~rem_diff[WIDTH];
        if (op_q == CTRL_MUL) begin
            acc_next = acc_q + (b_q[0] ? a_q : '0);
            a_next   = a_q << 1;
            b_next   = b_q >> 1;
        end else begin
            acc_next = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
            a_next   = {a_q[WIDTH-2:0], rem_ge};
            b_next   = b_q;
        end
        final_res = (op_q == CTRL_DIVU) ? a_next : acc_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && dec_multi) state_d = BUSY;
            BUSY:    if (flush_i || (cnt_q == '0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            op_q       <= 4'b0000;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            valid_o    <= 1'b0;
            result_o   <= '0;
            zero_o     <= 1'b0;
            alu_ctrl_o <= 4'b0000;
            illegal_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (state_q == IDLE) begin
                if (accept) begin
                    if (dec_multi) begin
                        a_q   <= src1_i;
                        b_q   <= src2_i;
                        acc_q <= '0;
                        op_q  <= dec_ctrl;
                        cnt_q <= CW'(WIDTH - 1);
                    end else begin
                        result_o   <= single_res;
                        zero_o     <= (single_res == '0);
                        alu_ctrl_o <= dec_ctrl;
                        illegal_o  <= dec_illegal;
                        valid_o    <= 1'b1;
                    end
                end
            end else if (flush_i) begin
                cnt_q <= '0;
            end else begin
                a_q   <= a_next;
                b_q   <= b_next;
                acc_q <= acc_next;
                if (cnt_q == '0) begin
                    result_o   <= final_res;
                    zero_o     <= (final_res == '0);
                    alu_ctrl_o <= op_q;
                    illegal_o  <= 1'b0;
                    valid_o    <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - scoreboard bench for alu_seq_unit at WIDTH 32 and 8
module tb_alu_seq_unit;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  ctrl;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, valid_i, flush;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] s1, s2;
    logic        ready_o, valid_o, zero_o, illegal_o;
    logic [31:0] result_o;
    logic [3:0]  alu_ctrl_o;

    logic        v8, fl8, rdy8, vo8, z8, ill8;
    logic [1:0]  op8;
    logic [5:0]  f8;
    logic [7:0]  a8, b8, res8;
    logic [3:0]  ctrl8;

    int          compared = 0;
    int          mismatched = 0;
    exp_t        sb[$];
    logic [31:0] last_res;

    always #5 clk = ~clk;

    alu_seq_unit #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ALUOp_i(aluop), .funct_i(funct),
        .src1_i(s1), .src2_i(s2), .flush_i(flush), .ready_o(ready_o), .valid_o(valid_o),
        .result_o(result_o), .zero_o(zero_o), .alu_ctrl_o(alu_ctrl_o), .illegal_o(illegal_o)
    );

    alu_seq_unit #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .valid_i(v8), .ALUOp_i(op8), .funct_i(f8),
        .src1_i(a8), .src2_i(b8), .flush_i(fl8), .ready_o(rdy8), .valid_o(vo8),
        .result_o(res8), .zero_o(z8), .alu_ctrl_o(ctrl8), .illegal_o(ill8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [63:0] p;
        e = '0;
        p = {32'b0, a} * {32'b0, b};
        case (op)
            2'b00: begin e.ctrl = 4'b0010; e.res = a + b; end
            2'b01: begin e.ctrl = 4'b0110; e.res = a - b; end
            2'b10: begin
                case (f)
                    6'b100011: begin e.ctrl = 4'b0010; e.res = a + b; end
                    6'b100001: begin e.ctrl = 4'b0110; e.res = a - b; end
                    6'b100110: begin e.ctrl = 4'b0000; e.res = a & b; end
                    6'b100101: begin e.ctrl = 4'b0001; e.res = a | b; end
                    6'b101011: begin e.ctrl = 4'b1100; e.res = ~(a | b); end
                    6'b101000: begin e.ctrl = 4'b0111; e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                    6'b011000: begin e.ctrl = 4'b1000; e.res = p[31:0]; end
                    6'b011011: begin e.ctrl = 4'b1001; e.res = (b == 0) ? 32'hFFFF_FFFF : a / b; end
                    6'b011001: begin e.ctrl = 4'b1010; e.res = (b == 0) ? a : a % b; end
                    default:   e.ill = 1'b1;
                endcase
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic bit is_multi(input exp_t e);
        return !e.ill && (e.ctrl == 4'b1000 || e.ctrl == 4'b1001 || e.ctrl == 4'b1010);
    endfunction

    task automatic send(input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        e = model(op, f, a, b);
        aluop = op; funct = f; s1 = a; s2 = b; valid_i = 1'b1;
        if (push) begin
            sb.push_back(e);
            last_res = e.res;
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
        if (push && !is_multi(e)) check("single_latency_valid", valid_o, 1);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b, input bit spurious);
        int lat, low;
        send(op, f, a, b, 1'b1);
        if (is_multi(model(op, f, a, b))) begin
            lat = 0; low = 0;
            while (!valid_o && lat < 100) begin
                if (!ready_o) low++;
                if (spurious && lat == 3) begin
                    aluop = 2'b00; s1 = $urandom; s2 = $urandom; valid_i = 1'b1;
                end
                if (lat == 6) valid_i = 1'b0;
                @(posedge clk); #1;
                lat++;
            end
            check("multi_latency", lat, 32);
            check("busy_ready_low_cycles", low, 32);
        end
    endtask

    task automatic run8(input logic [5:0] f, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input logic [3:0] expc);
        int lat;
        op8 = 2'b10; f8 = f; a8 = a; b8 = b; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        lat = 0;
        while (!vo8 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w8_latency", lat, 8);
        check("w8_result", res8, exp);
        check("w8_ctrl", ctrl8, expc);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid_o", valid_o, 0);
                end else begin
                    e = sb.pop_front();
                    check("result", result_o, e.res);
                    check("zero", zero_o, (e.res == 0));
                    check("alu_ctrl", alu_ctrl_o, e.ctrl);
                    check("illegal", illegal_o, e.ill);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  op;
        logic [5:0]  f;
        logic [31:0] a, b;
        logic [5:0]  ftab [9];
        ftab = '{6'b100011, 6'b100001, 6'b100110, 6'b100101, 6'b101011,
                 6'b101000, 6'b011000, 6'b011011, 6'b011001};
        rst = 1'b1; valid_i = 1'b0; flush = 1'b0; aluop = 2'b00; funct = 6'd0; s1 = 0; s2 = 0;
        v8 = 1'b0; fl8 = 1'b0; op8 = 2'b00; f8 = 6'd0; a8 = 0; b8 = 0;
        last_res = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_ready", ready_o, 1);
        check("reset_valid", valid_o, 0);
        check("reset_result", result_o, 0);
        check("reset_ctrl", alu_ctrl_o, 0);
        check("reset_illegal", illegal_o, 0);
        check("reset_zero", zero_o, 0);

        run_op(2'b10, 6'b100001, 32'd5, 32'd7, 0);
        run_op(2'b10, 6'b101000, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(2'b00, 6'd0, 32'd3, 32'hFFFF_FFFD, 0);
        run_op(2'b10, 6'b011000, 32'h0000_FFFF, 32'h0001_0001, 1);
        run_op(2'b10, 6'b011011, 32'd100, 32'd7, 0);
        run_op(2'b10, 6'b011001, 32'd100, 32'd7, 0);
        run_op(2'b10, 6'b011011, 32'h1234_5678, 32'd0, 0);
        run_op(2'b10, 6'b011001, 32'd9, 32'd0, 0);

        send(2'b10, 6'b011011, 32'd1000, 32'd3, 0);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_ready", ready_o, 1);
        check("flush_no_valid", valid_o, 0);
        check("flush_result_kept", result_o, last_res);
        repeat (40) @(posedge clk);
        #1;

        aluop = 2'b00; s1 = 32'd1; s2 = 32'd1; valid_i = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; flush = 1'b0;
        check("idle_flush_no_valid", valid_o, 0);
        check("idle_flush_result_kept", result_o, last_res);

        send(2'b10, 6'b011000, 32'd12345, 32'd678, 0);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_res = 0;
        check("midop_reset_ready", ready_o, 1);
        check("midop_reset_valid", valid_o, 0);
        check("midop_reset_result", result_o, 0);
        check("midop_reset_ctrl", alu_ctrl_o, 0);
        check("midop_reset_illegal", illegal_o, 0);
        repeat (40) @(posedge clk);
        #1;

        run_op(2'b11, 6'b100011, 32'd4, 32'd5, 0);
        run_op(2'b10, 6'b111111, 32'd4, 32'd5, 0);

        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            op = (r == 0) ? 2'b11 : (r == 1) ? 2'b00 : (r == 2) ? 2'b01 : 2'b10;
            r = $urandom_range(0, 9);
            f = (r == 9) ? 6'($urandom) : ftab[r];
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            r = $urandom_range(0, 5);
            b = (r == 0) ? 32'd0 : (r == 1) ? 32'($urandom_range(1, 20)) : $urandom;
            run_op(op, f, a, b, ($urandom_range(0, 1) == 1));
        end

        run8(6'b011000, 8'd15, 8'd17, 8'hFF, 4'b1000);
        run8(6'b011011, 8'd100, 8'd7, 8'd14, 4'b1001);
        run8(6'b011001, 8'd9, 8'd0, 8'd9, 4'b1010);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised execute-stage ALU with integrated ALU-control decode and an iterative multiply/divide engine. It takes the ALUOp/funct pair from the main controller plus two operands, decodes the operation, and returns a registered result over a valid/ready handshake. Logic ops (add, sub, and, or, nor, slt) complete in one cycle. Multiply and divide run multi-cycle, and `ready_o` stalls the pipeline while they do.

## Interface
- `WIDTH`, default 32: operand and result width; legal range 4–64.
- `clk_i` input, 1 bit: clock; all state updates on the rising edge.
- `rst_i` input, 1 bit: reset, synchronous, active-high.
- `valid_i` input, 1 bit: request strobe; accepted when `valid_i & ready_o`.
- `ALUOp_i` input, 2 bits: controller class. 00 = add, 01 = sub, 10 = R-type (use funct), 11 = illegal.
- `funct_i` input, 6 bits: R-type function field.
- `src1_i` input, WIDTH bits: operand A (dividend, multiplicand).
- `src2_i` input, WIDTH bits: operand B (divisor, multiplier).
- `flush_i` input, 1 bit: cancels any in-flight operation.
- `ready_o` output, 1 bit: unit can accept a request this cycle.
- `valid_o` output, 1 bit: one-cycle pulse; `result_o`, `zero_o`, `alu_ctrl_o` and `illegal_o` are valid.
- `result_o` output, WIDTH bits: result; holds until the next `valid_o`.
- `zero_o` output, 1 bit: `result_o == 0`.
- `alu_ctrl_o` output, 4 bits: decoded op code of the completed result.
- `illegal_o` output, 1 bit: the completed request was undecodable.

## Operation
- Funct decode (ALUOp 10) and resulting `alu_ctrl_o` code:
  - 100011 add → 0010
  - 100001 sub → 0110
  - 100110 and → 0000
  - 100101 or → 0001
  - 101011 nor → 1100
  - 101000 slt → 0111
  - 011000 mul → 1000
  - 011011 divu → 1001
  - 011001 remu → 1010
- ALUOp 00 gives 0010; ALUOp 01 gives 0110.
- Illegal request (ALUOp 11, or an unlisted funct with ALUOp 10): single-cycle completion with `result_o`=0, `alu_ctrl_o`=0000, `illegal_o`=1.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH.
  - slt is a signed WIDTH-bit compare giving 1 or 0.
  - mul returns the low WIDTH bits of the product; sign-agnostic, shift-add, one bit per cycle.
  - divu/remu are unsigned restoring division, one quotient bit per cycle.
- Divide by zero: divu returns all-ones; remu returns `src1_i`. The full iteration count still runs.
- FSM states:
  - IDLE: `ready_o`=1. Single-cycle op: result registered and `valid_o`=1 in the next cycle; state stays IDLE. mul/divu/remu: operands latched, iteration counter set to WIDTH-1, go to BUSY.
  - BUSY: `ready_o`=0, one iteration per cycle. When the counter reaches 0 and that iteration completes: load `result_o`, assert `valid_o`, return to IDLE.
- `ready_o` = (state == IDLE); driven from the registered state only, with no combinational path from `valid_i`.
- `flush_i`:
  - In BUSY: return to IDLE on that edge with no `valid_o`; the counter and partial results are discarded.
  - In IDLE with `valid_i`: the request is dropped, no `valid_o` is produced, and the previous `result_o` is kept.
- `valid_i` while `ready_o`=0 is ignored; it is the upstream's job to hold the request.
- Reset values: state IDLE, counter 0, `result_o`=0, `zero_o`=0, `valid_o`=0, `illegal_o`=0, `alu_ctrl_o`=0000, `ready_o`=1 in the first cycle after reset.
- Reset during BUSY aborts the operation; no `valid_o` is produced.

## Timing
- Single-cycle ops: accepted at edge E0, `valid_o` high in the cycle after E0. Throughput is 1 per cycle for back-to-back requests.
- mul/divu/remu: accepted at E0, iterations on edges E1…E_WIDTH. `valid_o` is high in the cycle after E_WIDTH, so latency is WIDTH cycles (32 at the default).
- In the `valid_o` cycle of a multi-cycle op `ready_o`=1, so a new request can be accepted with no bubble.
- `valid_o` is never asserted for two consecutive cycles from the same request.

## Test plan
- Reset, then `ALUOp`=10, `funct`=100001, 5 − 7 (WIDTH 32) → next cycle `valid_o`=1, `result_o`=0xFFFFFFFE, `alu_ctrl_o`=0110, `zero_o`=0.
- Back-to-back: slt(−1, 1) then add(3, −3) on consecutive cycles → `result_o` 1 then 0 on consecutive cycles; `zero_o` 0 then 1.
- mul 0xFFFF × 0x10001 → `ready_o` low for 32 cycles, then `valid_o`=1 with `result_o`=0xFFFFFFFF and `alu_ctrl_o`=1000. A `valid_i` raised during BUSY is ignored.
- divu 100 / 7 → 14; remu 100 / 7 → 2. divu x / 0 → 0xFFFFFFFF; remu 9 / 0 → 9. Each takes 32 cycles.
- `flush_i` at iteration 10 of a divu → no `valid_o`, `ready_o`=1 next cycle, `result_o` unchanged. Repeat with `rst_i` mid-op → all outputs return to reset values.
- `ALUOp`=11, then funct 111111 → `valid_o` with `illegal_o`=1, `result_o`=0, `alu_ctrl_o`=0000. Rerun a mul/div subset at WIDTH=8: mul 15 × 17 → 0xFF after 8 cycles.
